// File: rtl/arm_pkg.sv
// Shared ARM encoding definitions for the instruction encoder slice.
// Contents:
//   kind_t   descriptor kinds (values 5-7 are illegal and have no enumerator)
//   alu_t    data-processing operation selector
//   CMD_*    ARM data-processing opcode field values for bits [24:21]
//   OP_*     ARM major op field values for bits [27:26]
//   cmd_of   maps an alu selector onto its opcode field
package arm_pkg;

    typedef enum logic [2:0] {
        DP_IMM = 3'd0,
        DP_REG = 3'd1,
        LDR    = 3'd2,
        STR    = 3'd3,
        B      = 3'd4
    } kind_t;

    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        AND = 2'b10,
        ORR = 2'b11
    } alu_t;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_B   = 2'b10;

    function automatic logic [3:0] cmd_of(input logic [1:0] alu);
        logic [3:0] cmd;
        case (alu)
            ADD:     cmd = CMD_ADD;
            SUB:     cmd = CMD_SUB;
            AND:     cmd = CMD_AND;
            default: cmd = CMD_ORR;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Purely combinational descriptor packer: turns one instruction descriptor into a
// 32-bit ARM machine word and flags descriptors that cannot be encoded.
// Ports:
//   kind/cond/alu/s/rd/rn/rm/imm  descriptor fields (see arm_pkg for kind/alu values)
//   word                          encoded instruction (0 when illegal)
//   illegal                       kind 5-7, or immediate too wide for its form
module instr_pack
    import arm_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [3:0]  cond,
    input  logic [1:0]  alu,
    input  logic        s,
    input  logic [3:0]  rd,
    input  logic [3:0]  rn,
    input  logic [3:0]  rm,
    input  logic [23:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic [3:0] cmd;

    always_comb begin
        cmd     = cmd_of(alu);
        word    = '0;
        illegal = 1'b0;
        case (kind)
            DP_IMM: begin
                word    = {cond, OP_DP, 1'b1, cmd, s, rn, rd, 4'b0000, imm[7:0]};
                illegal = |imm[23:8];
            end
            DP_REG: begin
                word = {cond, OP_DP, 1'b0, cmd, s, rn, rd, 8'h00, rm};
            end
            LDR, STR: begin
                // Pre-indexed, add offset, word access, no writeback; L distinguishes load.
                word    = {cond, OP_MEM, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (kind == LDR),
                           rn, rd, imm[11:0]};
                illegal = |imm[23:12];
            end
            B: begin
                word = {cond, OP_B, 2'b10, imm};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
        if (illegal) begin
            word = '0;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// Program loader: accepts a stream of instruction descriptors, encodes each into an
// ARM word and writes it sequentially into instruction memory from a base address.
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   cfg_start/base/len    run configuration (start honoured only when idle or done)
//   in_valid/in_ready     descriptor handshake; in_* descriptor fields
//   imem_we/gnt/addr/wd   memory write request, held stable until granted
//   busy                  run in progress
//   done                  one-cycle pulse on run completion
//   err                   sticky illegal-descriptor flag, cleared on start
module instr_encoder
    import arm_pkg::*;
#(
    parameter int unsigned LENW = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cfg_start,
    input  logic [31:0]     cfg_base,
    input  logic [LENW-1:0] cfg_len,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_kind,
    input  logic [3:0]      in_cond,
    input  logic [1:0]      in_alu,
    input  logic            in_s,
    input  logic [3:0]      in_rd,
    input  logic [3:0]      in_rn,
    input  logic [3:0]      in_rm,
    input  logic [23:0]     in_imm,
    output logic            imem_we,
    input  logic            imem_gnt,
    output logic [31:0]     imem_addr,
    output logic [31:0]     imem_wd,
    output logic            busy,
    output logic            done,
    output logic            err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t          state_q, state_d;
    logic [LENW-1:0] accepted_q, accepted_d;
    logic [LENW-1:0] len_q, len_d;
    logic [31:0]     ptr_q, ptr_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wd_q, wd_d;
    logic            err_q, err_d;
    logic            done_q, done_d;

    logic [31:0] pack_word;
    logic        pack_illegal;
    logic        accept;
    logic        unused_base;

    assign unused_base = ^cfg_base[1:0];

    instr_pack u_pack (
        .kind    (in_kind),
        .cond    (in_cond),
        .alu     (in_alu),
        .s       (in_s),
        .rd      (in_rd),
        .rn      (in_rn),
        .rm      (in_rm),
        .imm     (in_imm),
        .word    (pack_word),
        .illegal (pack_illegal)
    );

    // The output register may refill in the same cycle it is granted.
    assign in_ready = (state_q == StRun) && (accepted_q < len_q) && (!we_q || imem_gnt);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        accepted_d = accepted_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wd_d       = wd_q;
        err_d      = err_q;
        done_d     = 1'b0;

        if (we_q && imem_gnt) begin
            we_d = 1'b0;
        end

        case (state_q)
            StIdle, StDone: begin
                if (cfg_start) begin
                    len_d      = cfg_len;
                    accepted_d = '0;
                    ptr_d      = {cfg_base[31:2], 2'b00};
                    err_d      = 1'b0;
                    if (cfg_len == '0) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    accepted_d = accepted_q + 1'b1;
                    if (pack_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        wd_d   = pack_word;
                        addr_d = ptr_q;
                        ptr_d  = ptr_q + 32'd4;
                    end
                end
                // Use next-state values so done follows the final grant/consume directly.
                if ((accepted_d == len_q) && !we_d) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            accepted_q <= '0;
            len_q      <= '0;
            ptr_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            accepted_q <= accepted_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
            done_q     <= done_d;
        end
    end

    assign imem_we   = we_q;
    assign imem_addr = addr_q;
    assign imem_wd   = wd_q;
    assign busy      = (state_q == StRun);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: table-driven descriptor runs plus hand-written
// sequences for write stall, zero-length run and asynchronous reset mid-run.
module tb_instr_encoder;

    localparam int unsigned LENW = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_start = 1'b0;
    logic [31:0]     cfg_base = '0;
    logic [LENW-1:0] cfg_len = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_kind = '0;
    logic [3:0]      in_cond = '0;
    logic [1:0]      in_alu = '0;
    logic            in_s = 1'b0;
    logic [3:0]      in_rd = '0;
    logic [3:0]      in_rn = '0;
    logic [3:0]      in_rm = '0;
    logic [23:0]     in_imm = '0;
    logic            imem_we;
    logic            imem_gnt = 1'b1;
    logic [31:0]     imem_addr;
    logic [31:0]     imem_wd;
    logic            busy;
    logic            done;
    logic            err;

    instr_encoder #(.LENW(LENW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg_start (cfg_start),
        .cfg_base  (cfg_base),
        .cfg_len   (cfg_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_cond   (in_cond),
        .in_alu    (in_alu),
        .in_s      (in_s),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_imm    (in_imm),
        .imem_we   (imem_we),
        .imem_gnt  (imem_gnt),
        .imem_addr (imem_addr),
        .imem_wd   (imem_wd),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  cond;
        logic [1:0]  alu;
        logic        s;
        logic [3:0]  rd;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic [23:0] imm;
        logic [31:0] word;
        logic        ill;
    } vec_t;

    vec_t vecs[10];

    int errors = 0;
    int checks = 0;

    // Write/done monitor: a write is granted at the edge following a cycle with we&gnt.
    int          cyc = 0;
    int          done_cnt = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_wd[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we && imem_gnt) begin
            q_addr.push_back(imem_addr);
            q_wd.push_back(imem_wd);
            q_cyc.push_back(cyc);
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    function automatic vec_t mk(input logic [2:0] kind, input logic [3:0] cond,
                                input logic [1:0] alu, input logic s, input logic [3:0] rd,
                                input logic [3:0] rn, input logic [3:0] rm,
                                input logic [23:0] imm, input logic [31:0] word,
                                input logic ill);
        vec_t v;
        v.kind = kind; v.cond = cond; v.alu = alu; v.s = s;
        v.rd = rd; v.rn = rn; v.rm = rm; v.imm = imm;
        v.word = word; v.ill = ill;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input int i);
        in_kind = vecs[i].kind;
        in_cond = vecs[i].cond;
        in_alu  = vecs[i].alu;
        in_s    = vecs[i].s;
        in_rd   = vecs[i].rd;
        in_rn   = vecs[i].rn;
        in_rm   = vecs[i].rm;
        in_imm  = vecs[i].imm;
    endtask

    task automatic start(input logic [31:0] base, input logic [LENW-1:0] len);
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_base  = base;
        cfg_len   = len;
        @(posedge clk); #1;
        cfg_start = 1'b0;
    endtask

    task automatic feed(input string name, input int first, input int n);
        int   idx = first;
        int   budget = 0;
        logic acc;
        while (idx < first + n && budget < 300) begin
            drive(idx);
            in_valid = 1'b1;
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            budget++;
        end
        in_valid = 1'b0;
        checks++;
        if (idx != first + n) begin
            errors++;
            $display("FAIL %s_feed: accepted %0d expected %0d", name, idx - first, n);
        end
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 100);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_done_timeout: done=0 after %0d cycles expected 1", name, k);
        end
    endtask

    task automatic run_table(input string name, input int first, input int n,
                             input logic [31:0] base, input logic exp_err, input logic b2b);
        int          s0 = q_addr.size();
        int          d0 = done_cnt;
        int          j = 0;
        logic [31:0] ea;
        start(base, n[LENW-1:0]);
        feed(name, first, n);
        wait_done(name);
        repeat (3) @(posedge clk);
        #1;
        for (int i = first; i < first + n; i++) begin
            if (!vecs[i].ill) begin
                ea = (base & ~32'h3) + 32'(4 * j);
                if (s0 + j < q_addr.size()) begin
                    check($sformatf("%s_addr%0d", name, j), q_addr[s0 + j], ea);
                    check($sformatf("%s_wd%0d", name, j), q_wd[s0 + j], vecs[i].word);
                    if (b2b && j > 0) begin
                        check($sformatf("%s_b2b%0d", name, j),
                              32'(q_cyc[s0 + j] - q_cyc[s0 + j - 1]), 32'd1);
                    end
                end
                j++;
            end
        end
        check({name, "_nwrites"}, 32'(q_addr.size() - s0), 32'(j));
        check({name, "_ndone"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int s0;
        int d0;

        //            kind  cond   alu    s     rd     rn     rm     imm          word
        vecs[0] = mk(3'd0, 4'hE, 2'b00, 1'b0, 4'd1, 4'd2, 4'd0, 24'h000005, 32'hE2821005, 1'b0);
        vecs[1] = mk(3'd1, 4'h0, 2'b01, 1'b1, 4'd3, 4'd4, 4'd5, 24'h000000, 32'h00543005, 1'b0);
        vecs[2] = mk(3'd2, 4'hE, 2'b00, 1'b0, 4'd2, 4'd0, 4'd0, 24'h000008, 32'hE5902008, 1'b0);
        vecs[3] = mk(3'd3, 4'hE, 2'b00, 1'b0, 4'd2, 4'd0, 4'd0, 24'h000054, 32'hE5802054, 1'b0);
        vecs[4] = mk(3'd4, 4'hE, 2'b00, 1'b0, 4'd0, 4'd0, 4'd0, 24'hFFFFFD, 32'hEAFFFFFD, 1'b0);
        vecs[5] = mk(3'd0, 4'hE, 2'b10, 1'b0, 4'd0, 4'd1, 4'd0, 24'h0000FF, 32'hE20100FF, 1'b0);
        vecs[6] = mk(3'd0, 4'hE, 2'b11, 1'b0, 4'd1, 4'd1, 4'd0, 24'h000100, 32'h0,        1'b1);
        vecs[7] = mk(3'd5, 4'hE, 2'b00, 1'b0, 4'd1, 4'd1, 4'd0, 24'h000000, 32'h0,        1'b1);
        vecs[8] = mk(3'd2, 4'hE, 2'b00, 1'b0, 4'd1, 4'd1, 4'd0, 24'h001000, 32'h0,        1'b1);
        vecs[9] = mk(3'd1, 4'h1, 2'b11, 1'b0, 4'd6, 4'd7, 4'd8, 24'h000000, 32'h11876008, 1'b0);

        #2 reset = 1'b0;
        #1;
        check("rst_we", {31'd0, imem_we}, 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wd", imem_wd, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;

        run_table("add1", 0, 1, 32'h0000_0100, 1'b0, 1'b0);
        run_table("b2b", 1, 4, 32'h0000_0200, 1'b0, 1'b1);
        run_table("illegal", 5, 5, 32'h0000_0300, 1'b1, 1'b0);

        // Zero-length run: done in the cycle after start, no writes, err cleared by start.
        s0 = q_addr.size();
        d0 = done_cnt;
        @(posedge clk); #1;
        cfg_start = 1'b1;
        cfg_base  = 32'h0000_0400;
        cfg_len   = '0;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        @(negedge clk);
        check("len0_done", {31'd0, done}, 32'd1);
        check("len0_busy", {31'd0, busy}, 32'd0);
        check("len0_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        check("len0_done_pulse", {31'd0, done}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("len0_nwrites", 32'(q_addr.size() - s0), 32'd0);
        check("len0_ndone", 32'(done_cnt - d0), 32'd1);

        run_table("wrap", 3, 2, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Grant held low for three cycles: write held stable, no further descriptor taken.
        s0 = q_addr.size();
        imem_gnt = 1'b0;
        start(32'h0000_0600, 8'd2);
        drive(0);
        in_valid = 1'b1;
        @(negedge clk);
        check("stall_ready0", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        drive(1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("stall_we%0d", k), {31'd0, imem_we}, 32'd1);
            check($sformatf("stall_addr%0d", k), imem_addr, 32'h0000_0600);
            check($sformatf("stall_wd%0d", k), imem_wd, 32'hE2821005);
            check($sformatf("stall_ready%0d", k), {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        check("stall_ready_gnt", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_done("stall");
        repeat (2) @(posedge clk);
        #1;
        check("stall_nwrites", 32'(q_addr.size() - s0), 32'd2);
        if (q_addr.size() - s0 == 2) begin
            check("stall_addrA", q_addr[s0], 32'h0000_0600);
            check("stall_wdA", q_wd[s0], 32'hE2821005);
            check("stall_addrB", q_addr[s0 + 1], 32'h0000_0604);
            check("stall_wdB", q_wd[s0 + 1], 32'h00543005);
        end

        // Asynchronous reset with a write pending.
        imem_gnt = 1'b0;
        start(32'h0000_0700, 8'd2);
        drive(2);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_pre_we", {31'd0, imem_we}, 32'd1);
        check("midrst_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("midrst_we", {31'd0, imem_we}, 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_wd", imem_wd, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        imem_gnt = 1'b1;
        run_table("rerun", 0, 1, 32'h0000_0500, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
